posit_encode_sum_es3: RTL and testbench
=======================================

POSIT_ENCODE_SUM_ES3 -- requirements
Module: posit_encode_sum_es3

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-002 SHALL have port start  input  1  input sum valid for this cycle; X on start treated as 0.
REQ-003 SHALL have port in_sum  input  42  raw sum from the es3 adder: [41] sgn, [40:32] scale (signed 9b), [31:2] fraction (30b, hidden bit excluded, MSB-aligned), [1] inf, [0] zero.
REQ-004 SHALL have port truncated  input  1  adder sticky flag: nonzero bits lost below fraction[0].
REQ-005 SHALL have port result  output  32  packed posit, n=32, es=3, two's-complement encoding.
REQ-006 SHALL have port done  output  1  result valid for this cycle.
REQ-007 SHALL have no parameters; widths fixed by the es3 package.

Function
REQ-008 SHALL be fully pipelined: 3 register stages, done asserted exactly 3 clk edges after the start sample, one result per cycle, no stalls, no backpressure.
REQ-009 SHALL carry a valid bit per stage; done equals the stage-3 valid bit; result holds its last value when done=0.
REQ-010 SHALL, stage 1, register in_sum, truncated, start.
REQ-011 SHALL, stage 2, split scale: k = scale >>> 3 (arithmetic), e = scale[2:0].
REQ-012 SHALL build regime: k>=0 -> (k+1) ones then one zero; k<0 -> (-k) zeros then one one.
REQ-013 SHALL form magnitude string {regime, e[2:0], fraction[29:0]}, left-aligned under the sign bit, shifted right by regime length, into a 64-bit field.
REQ-014 SHALL take top 31 bits of that field as mag; guard = next bit; sticky = OR of all lower bits OR truncated.
REQ-015 SHALL, stage 3, round to nearest even: mag += guard & (mag[0] | sticky).
REQ-016 SHALL clamp: rounding overflow past 0x7FFFFFFF -> 0x7FFFFFFF; mag 0 after rounding with zero=0 -> 1 (posit never rounds to zero).
REQ-017 SHALL saturate scale > 240 -> mag 0x7FFFFFFF (maxpos); scale < -240 -> mag 0x00000001 (minpos); round step skipped for saturated values.
REQ-018 SHALL output result = {1'b0, mag} if sgn=0, else two's complement of {1'b0, mag}.
REQ-019 SHALL give priority inf > zero > normal: inf=1 -> 0x80000000 regardless of other fields; zero=1 (inf=0) -> 0x00000000.
REQ-020 SHALL treat each input independently; no state carried between results except pipeline registers.

Reset
REQ-021 SHALL, while rst=1 at a clk edge, clear all stage valid bits, done=0, result=0x00000000.
REQ-022 SHALL discard in-flight values when rst asserts mid-pipeline; no done for them after reset release.
REQ-023 SHALL accept start in the first cycle after rst deasserts; done follows 3 cycles later.

Verification
REQ-024 SHALL pass: scale 0, fraction 0, sgn 0 -> 0x40000000; same with sgn 1 -> 0xC0000000; done exactly 3 cycles after start.
REQ-025 SHALL pass: scale 1 -> 0x44000000; scale 8 -> 0x60000000; scale -8 -> 0x20000000.
REQ-026 SHALL pass: scale 0, fraction[3:0]=4'b1000, rest 0, truncated 0 -> 0x40000000 (tie to even); same with truncated 1 -> 0x40000001.
REQ-027 SHALL pass: scale 255 -> 0x7FFFFFFF; scale -256 -> 0x00000001; scale 255 sgn 1 -> 0x80000001.
REQ-028 SHALL pass: inf=1 with zero=1 -> 0x80000000; zero=1 -> 0x00000000.
REQ-029 SHALL pass: start high on 5 consecutive cycles, rst pulsed on cycle 2 -> only inputs sampled after rst release produce done; each done is 3 cycles after its start, in order.

Source files
------------

// File: rtl/posit_encode_sum_es3.sv
// -----------------------------------------------------------------------------
// posit_encode_sum_es3
//
// Final encode stage behind an es=3 posit adder. Takes the adder's unpacked
// raw sum (sign, signed scale, 30-bit fraction, inf/zero flags) plus a sticky
// flag and produces a packed 32-bit posit (es=3) with round-to-nearest-even.
//
// Three register stages, one result per cycle, no stalls:
//   stage 1 : capture raw sum, sticky flag and start
//   stage 2 : split scale into regime k / exponent e, assemble the regime-
//             exponent-fraction string, extract mag / guard / sticky
//   stage 3 : round, clamp, saturate, apply sign and special values
//
// Ports
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous active-high reset
//   start      in   1  in_sum valid this cycle (X treated as 0)
//   in_sum     in  42  [41] sgn, [40:32] scale (signed), [31:2] fraction
//                      (hidden bit excluded, MSB-aligned), [1] inf, [0] zero
//   truncated  in   1  adder sticky: nonzero bits lost below fraction[0]
//   result     out 32  packed posit; holds its last value while done=0
//   done       out  1  result valid this cycle, 3 edges after start sample
// -----------------------------------------------------------------------------
module posit_encode_sum_es3 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [41:0] in_sum,
  input  logic        truncated,
  output logic [31:0] result,
  output logic        done
);

  // Stage 1 payload: the raw adder output, unpacked for readability.
  typedef struct packed {
    logic              sgn;
    logic signed [8:0] scale;
    logic [29:0]       frac;
    logic              inf;
    logic              zero;
    logic              trunc;
  } s1_t;

  // Stage 2 payload: unrounded magnitude plus the rounding bits and the
  // special-case flags that stage 3 needs to pick the final encoding.
  typedef struct packed {
    logic        sgn;
    logic        inf;
    logic        zero;
    logic        sat_hi;
    logic        sat_lo;
    logic [30:0] mag;
    logic        guard;
    logic        sticky;
  } s2_t;

  // Saturation thresholds: beyond these the regime alone fills all 31
  // magnitude bits, so the value pins to maxpos / minpos.
  localparam logic signed [8:0] SCALE_MAX = 9'sd240;
  localparam logic signed [8:0] SCALE_MIN = -9'sd240;

  localparam logic [30:0] MAG_MAXPOS = 31'h7FFF_FFFF;
  localparam logic [30:0] MAG_MINPOS = 31'h0000_0001;

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic        r_v1;
  logic        r_v2;
  logic        r_v3;
  s1_t         r_s1;
  s2_t         r_s2;
  logic [31:0] r_result;

  // ---------------------------------------------------------------------------
  // Stage 1 input unpack
  // ---------------------------------------------------------------------------
  s1_t w_s1;

  assign w_s1 = '{
    sgn:   in_sum[41],
    scale: in_sum[40:32],
    frac:  in_sum[31:2],
    inf:   in_sum[1],
    zero:  in_sum[0],
    trunc: truncated
  };

  // ---------------------------------------------------------------------------
  // Stage 2 combinational: regime/exponent split and string assembly
  // ---------------------------------------------------------------------------
  logic signed [8:0] w_scale;
  logic signed [5:0] w_k;
  logic [2:0]        w_e;
  logic [6:0]        w_reg_len;
  logic [63:0]       w_regime;
  logic [63:0]       w_body;
  logic [63:0]       w_field;
  s2_t               w_s2;

  // NOTE: combinational blocks use blocking assignments and give every
  // output a default first, so no path can leave a value unassigned and
  // infer a latch.
  always_comb begin
    w_scale = r_s1.scale;

    // scale >>> 3 keeps exactly the upper six bits of the 9-bit scale,
    // already sign-interpreted; e is the low three bits in either sign.
    w_k = w_scale[8:3];
    w_e = w_scale[2:0];

    // Regime length: k >= 0 gives (k+1) ones plus a terminating zero,
    // k < 0 gives (-k) zeros plus a terminating one.
    if (!w_k[5]) begin
      w_reg_len = {1'b0, w_k} + 7'd2;
    end else begin
      w_reg_len = 7'd1 - {w_k[5], w_k};
    end

    // Regime pattern, left-aligned at bit 63 (the first bit below the sign).
    if (!w_k[5]) begin
      w_regime = ~({64{1'b1}} >> (w_reg_len - 7'd1));
    end else begin
      w_regime = 64'h8000_0000_0000_0000 >> (w_reg_len - 7'd1);
    end

    // Exponent and fraction follow immediately after the regime.
    w_body  = {w_e, r_s1.frac, 31'd0} >> w_reg_len;
    w_field = w_regime | w_body;

    w_s2        = '0;
    w_s2.sgn    = r_s1.sgn;
    w_s2.inf    = r_s1.inf;
    w_s2.zero   = r_s1.zero;
    w_s2.sat_hi = (w_scale > SCALE_MAX);
    w_s2.sat_lo = (w_scale < SCALE_MIN);
    w_s2.mag    = w_field[63:33];
    w_s2.guard  = w_field[32];
    w_s2.sticky = (|w_field[31:0]) | r_s1.trunc;
  end

  // ---------------------------------------------------------------------------
  // Stage 3 combinational: round, clamp, sign, special values
  // ---------------------------------------------------------------------------
  logic [31:0] w_rnd_sum;
  logic        w_rnd_up;
  logic [30:0] w_mag;
  logic [31:0] w_signed;
  logic [31:0] w_result;

  always_comb begin
    // Round to nearest, ties to even.
    w_rnd_up  = r_s2.guard & (r_s2.mag[0] | r_s2.sticky);
    w_rnd_sum = {1'b0, r_s2.mag} + {31'd0, w_rnd_up};

    // Saturated scales skip rounding entirely. A rounded magnitude that
    // carries out of 31 bits pins to maxpos; a posit never rounds to zero.
    if (r_s2.sat_hi) begin
      w_mag = MAG_MAXPOS;
    end else if (r_s2.sat_lo) begin
      w_mag = MAG_MINPOS;
    end else if (w_rnd_sum[31]) begin
      w_mag = MAG_MAXPOS;
    end else if (w_rnd_sum[30:0] == 31'd0) begin
      w_mag = MAG_MINPOS;
    end else begin
      w_mag = w_rnd_sum[30:0];
    end

    // Negative posits are the two's complement of the positive encoding.
    if (r_s2.sgn) begin
      w_signed = 32'd0 - {1'b0, w_mag};
    end else begin
      w_signed = {1'b0, w_mag};
    end

    // inf outranks zero, which outranks a normal value.
    if (r_s2.inf) begin
      w_result = 32'h8000_0000;
    end else if (r_s2.zero) begin
      w_result = 32'h0000_0000;
    end else begin
      w_result = w_signed;
    end
  end

  // ---------------------------------------------------------------------------
  // Control state: valid bits and the output register
  // ---------------------------------------------------------------------------
  // NOTE: sequential blocks use non-blocking assignments so every register
  // samples the values from before the edge, which is what makes the stages
  // behave as a pipeline rather than a ripple.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_v3     <= 1'b0;
      r_result <= '0;
    end else begin
      // Written as an if so an unknown start falls through to 0.
      r_v1 <= 1'b0;
      if (start) begin
        r_v1 <= 1'b1;
      end
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      if (r_v2) begin
        r_result <= w_result;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: payload registers carry no reset; nothing downstream looks at them
  // unless the matching valid bit (which is reset) says they are live.
  always_ff @(posedge clk) begin
    if (start) begin
      r_s1 <= w_s1;
    end
    if (r_v1) begin
      r_s2 <= w_s2;
    end
  end

  assign result = r_result;
  assign done   = r_v3;

endmodule

// File: tb/tb_posit_encode_sum_es3.sv
// -----------------------------------------------------------------------------
// Testbench for posit_encode_sum_es3.
// Table of known encodings, latency/reset sequences, then randomized traffic
// checked against a bit-string reference model. Every cycle the bench checks
// done against an expectation queue and result against the last delivered
// value.
// -----------------------------------------------------------------------------
module tb_posit_encode_sum_es3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [41:0] in_sum;
  logic        truncated;
  logic [31:0] result;
  logic        done;

  posit_encode_sum_es3 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_sum    (in_sum),
    .truncated (truncated),
    .result    (result),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] res;
  } exp_t;

  typedef struct {
    logic [41:0] sum;
    bit          tr;
    logic [31:0] expv;
  } vec_t;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cyc = 0;
  exp_t        exp_q[$];
  logic [31:0] last_res = '0;
  bit          rst_pend = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s at cycle %0d: got %08h, expected %08h", name, cyc, act, req);
  endtask

  function automatic logic [41:0] mk(input bit sgn, input int scale, input logic [29:0] frac,
                                     input bit inf, input bit zero);
    logic [8:0] sc;
    sc = 9'(scale);
    return {sgn, sc, frac, inf, zero};
  endfunction

  // Reference: write out the regime, exponent and fraction bits one by one,
  // take the first 31 as the magnitude, then round on the remainder.
  function automatic logic [31:0] model(input logic [41:0] s, input bit tr);
    int          scale;
    int          k;
    int          e;
    bit          q[$];
    longint      mag;
    bit          guard;
    bit          sticky;
    logic [31:0] m32;
    if (s[1]) return 32'h8000_0000;
    if (s[0]) return 32'h0000_0000;
    scale = $signed(s[40:32]);
    if (scale > 240) mag = 64'h7FFF_FFFF;
    else if (scale < -240) mag = 1;
    else begin
      k = (scale >= 0) ? scale / 8 : -((-scale + 7) / 8);
      e = scale - 8 * k;
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        for (int i = 0; i < -k; i++) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      for (int i = 2; i >= 0; i--) q.push_back(e[i]);
      for (int i = 29; i >= 0; i--) q.push_back(s[2 + i]);
      mag = 0;
      for (int i = 0; i < 31; i++) mag = mag * 2 + ((i < q.size()) ? q[i] : 1'b0);
      guard  = (q.size() > 31) ? q[31] : 1'b0;
      sticky = tr;
      for (int i = 32; i < q.size(); i++) sticky |= q[i];
      if (guard && ((mag % 2 == 1) || sticky)) mag++;
      if (mag > 64'h7FFF_FFFF) mag = 64'h7FFF_FFFF;
      if (mag == 0) mag = 1;
    end
    m32 = mag[31:0];
    return s[41] ? (32'd0 - m32) : m32;
  endfunction

  // Apply inputs for the coming edge and record what should come out.
  task automatic drive(input bit st, input logic [41:0] s, input bit tr, input bit r,
                       input logic [31:0] expv);
    exp_t e;
    start     = st;
    in_sum    = s;
    truncated = tr;
    rst       = r;
    rst_pend  = r;
    if (st && !r) begin
      e.due = cyc + 3;
      e.res = expv;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_model(input bit st, input logic [41:0] s, input bit tr, input bit r);
    drive(st, s, tr, r, model(s, tr));
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  // Advance one clock and check the outputs just after the edge.
  task automatic step();
    bit exp_done;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_pend) begin
      exp_q.delete();
      last_res = '0;
    end
    exp_done = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    check("done", {31'd0, done}, {31'd0, exp_done});
    if (exp_done) begin
      last_res = exp_q[0].res;
      void'(exp_q.pop_front());
    end
    check("result", result, last_res);
  endtask

  vec_t vecs[18];

  initial begin
    vecs[0]  = '{mk(0,    0, 30'h0,  0, 0), 0, 32'h4000_0000};
    vecs[1]  = '{mk(1,    0, 30'h0,  0, 0), 0, 32'hC000_0000};
    vecs[2]  = '{mk(0,    1, 30'h0,  0, 0), 0, 32'h4400_0000};
    vecs[3]  = '{mk(0,    8, 30'h0,  0, 0), 0, 32'h6000_0000};
    vecs[4]  = '{mk(0,   -8, 30'h0,  0, 0), 0, 32'h2000_0000};
    vecs[5]  = '{mk(0,    0, 30'h8,  0, 0), 0, 32'h4000_0000};
    vecs[6]  = '{mk(0,    0, 30'h8,  0, 0), 1, 32'h4000_0001};
    vecs[7]  = '{mk(0,  255, 30'h0,  0, 0), 0, 32'h7FFF_FFFF};
    vecs[8]  = '{mk(0, -256, 30'h0,  0, 0), 0, 32'h0000_0001};
    vecs[9]  = '{mk(1,  255, 30'h0,  0, 0), 0, 32'h8000_0001};
    vecs[10] = '{mk(0,    5, 30'h3,  1, 1), 0, 32'h8000_0000};
    vecs[11] = '{mk(1,   17, 30'h5,  0, 1), 1, 32'h0000_0000};
    vecs[12] = '{mk(0,   -1, 30'h0,  0, 0), 0, 32'h3C00_0000};
    vecs[13] = '{mk(0,    0, 30'h18, 0, 0), 0, 32'h4000_0002};
    vecs[14] = '{mk(0,  239, 30'h0,  0, 0), 0, 32'h7FFF_FFFF};
    vecs[15] = '{mk(0,  240, 30'h0,  0, 0), 0, 32'h7FFF_FFFF};
    vecs[16] = '{mk(0, -240, 30'h1,  0, 0), 1, 32'h0000_0001};
    vecs[17] = '{mk(1,  241, 30'h0,  0, 0), 0, 32'h8000_0001};

    // Reset: done low, result cleared.
    drive(1'b0, '0, 1'b0, 1'b1, '0);
    step();
    step();

    // Known encodings, back to back, starting right after reset release.
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].sum, vecs[i].tr, 1'b0, vecs[i].expv);
      step();
    end
    idle();
    repeat (4) step();

    // Lone start: done exactly three cycles later, then result holds.
    drive(1'b1, mk(1, 8, 30'h0, 0, 0), 1'b0, 1'b0, 32'hA000_0000);
    step();
    idle();
    repeat (5) step();

    // Five consecutive starts with reset on the third: only the last two
    // emerge, in order.
    for (int i = 0; i < 5; i++) begin
      drive_model(1'b1, mk(0, 8 * i + 3, 30'h1234 * (i + 1), 0, 0), 1'b0, (i == 2));
      step();
    end
    idle();
    repeat (5) step();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 500; n++) begin
      int          scale;
      logic [29:0] frac;
      bit          r;
      case ($urandom_range(3, 0))
        0:       scale = int'($urandom_range(20, 0)) - 10;
        1:       scale = ($urandom_range(1, 0) == 1) ? int'($urandom_range(250, 230))
                                                     : -int'($urandom_range(250, 230));
        default: scale = int'($urandom_range(511, 0)) - 256;
      endcase
      frac = 30'($urandom);
      r    = ($urandom_range(99, 0) == 0);
      drive_model($urandom_range(3, 0) != 0,
                  mk($urandom_range(1, 0) == 1, scale, frac,
                     $urandom_range(15, 0) == 0, $urandom_range(15, 0) == 0),
                  $urandom_range(1, 0) == 1, r);
      step();
    end
    idle();
    repeat (5) step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
